// File: rtl/tcrc_reg_param_if.sv
// Bus bundle for the serial CRC register: bit-strobe controls in, CRC state and serialiser outputs back.
`timescale 1ns/1ps
interface tcrc_reg_param_if #(
    parameter int WIDTH = 15
) ();
    logic             enable;
    logic             load;
    logic [WIDTH-1:0] preload;
    logic             start_out;
    logic             Input;
    logic             check;
    logic             err_clr;
    logic [WIDTH-1:0] crc_q;
    logic             crc_zero;
    logic             out_bit;
    logic             out_valid;
    logic             out_done;
    logic             err_sticky;

    modport master (
        output enable, load, preload, start_out, Input, check, err_clr,
        input  crc_q, crc_zero, out_bit, out_valid, out_done, err_sticky
    );

    modport slave (
        input  enable, load, preload, start_out, Input, check, err_clr,
        output crc_q, crc_zero, out_bit, out_valid, out_done, err_sticky
    );
endinterface

// File: rtl/tcrc_reg_param.sv
// Serial CAN CRC register: MSB-first LFSR update per bit strobe, preload, and MSB-first CRC shift-out.
// Optional sticky receive-error flag enabled by defining CRC_STICKY_ERR_EN.
`timescale 1ns/1ps
module tcrc_reg_param #(
    parameter int             WIDTH     = 15,
    parameter logic [WIDTH-1:0] POLY      = 15'h4599,
    parameter logic [WIDTH-1:0] RESET_VAL = 15'h0000
) (
    input  logic            clock,
    input  logic            reset,
    tcrc_reg_param_if.slave bus
);
    localparam int               CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic {
        ST_CALC  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t           state_r;
    state_t           state_nxt_s;
    logic [WIDTH-1:0] crc_r;
    logic [WIDTH-1:0] crc_nxt_s;
    logic [WIDTH-1:0] crc_sh_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic             done_r;
    logic             done_nxt_s;
    logic             fb_s;
    logic             crc_zero_s;

    assign crc_sh_s   = {crc_r[WIDTH-2:0], 1'b0};
    assign fb_s       = bus.Input ^ crc_r[WIDTH-1];
    assign crc_zero_s = (crc_r == {WIDTH{1'b0}});

    // State, CRC, bit counter and done pulse registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r <= ST_CALC;
            crc_r   <= RESET_VAL;
            cnt_r   <= {CNT_W{1'b0}};
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            crc_r   <= crc_nxt_s;
            cnt_r   <= cnt_nxt_s;
            done_r  <= done_nxt_s;
        end
    end

    // Next-state logic; everything holds and done stays low without a bit strobe
    always_comb begin
        state_nxt_s = state_r;
        crc_nxt_s   = crc_r;
        cnt_nxt_s   = cnt_r;
        done_nxt_s  = 1'b0;
        if (bus.enable) begin
            case (state_r)
                ST_CALC: begin
                    if (bus.load) begin
                        crc_nxt_s = bus.preload;
                    end else if (bus.start_out) begin
                        state_nxt_s = ST_SHIFT;
                        cnt_nxt_s   = CNT_LAST;
                    end else begin
                        crc_nxt_s = crc_sh_s ^ (fb_s ? POLY : {WIDTH{1'b0}});
                    end
                end
                ST_SHIFT: begin
                    if (bus.load) begin
                        // Abort serialisation: no done pulse for a truncated field
                        crc_nxt_s   = bus.preload;
                        state_nxt_s = ST_CALC;
                        cnt_nxt_s   = {CNT_W{1'b0}};
                    end else begin
                        crc_nxt_s = crc_sh_s;
                        if (cnt_r == {CNT_W{1'b0}}) begin
                            state_nxt_s = ST_CALC;
                            done_nxt_s  = 1'b1;
                        end else begin
                            cnt_nxt_s = cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
                        end
                    end
                end
                default: begin
                    state_nxt_s = ST_CALC;
                end
            endcase
        end else begin
            done_nxt_s = 1'b0;
        end
    end

    assign bus.crc_q     = crc_r;
    assign bus.crc_zero  = crc_zero_s;
    assign bus.out_valid = (state_r == ST_SHIFT);
    assign bus.out_bit   = (state_r == ST_SHIFT) ? crc_r[WIDTH-1] : 1'b0;
    assign bus.out_done  = done_r;

`ifdef CRC_STICKY_ERR_EN
    logic err_r;
    logic err_set_s;

    assign err_set_s = bus.enable & bus.check & (state_r == ST_CALC) & ~crc_zero_s;

    // Sticky mismatch flag; a new mismatch outranks a simultaneous clear
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            err_r <= 1'b0;
        end else if (err_set_s) begin
            err_r <= 1'b1;
        end else if (bus.err_clr) begin
            err_r <= 1'b0;
        end else begin
            err_r <= err_r;
        end
    end

    assign bus.err_sticky = err_r;
`else
    logic unused_ok_s;
    assign unused_ok_s    = ^{bus.check, bus.err_clr};
    assign bus.err_sticky = 1'b0;
`endif
endmodule

// File: tb/tb_tcrc_reg_param.sv
// Scoreboard bench for tcrc_reg_param: polynomial-division reference model, queued expectations, negedge monitor.
`timescale 1ns/1ps
module tb_tcrc_reg_param;
    localparam int             W    = 15;
    localparam logic [W-1:0]   POLY = 15'h4599;

    typedef struct {
        logic [W-1:0] crc;
        logic         valid;
        logic         obit;
        logic         done;
        logic         zero;
        logic         err;
    } exp_t;

    logic clock;
    logic reset;
    logic en_seen;
    int   n_cmp;
    int   n_err;
    int   done_cnt;

    exp_t         sb[$];
    logic         emit_q[$];
    logic [W-1:0] m_crc;
    logic         m_err;

    tcrc_reg_param_if #(.WIDTH(W)) bus ();

    tcrc_reg_param #(
        .WIDTH    (W),
        .POLY     (POLY),
        .RESET_VAL(15'h0000)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(posedge clock or posedge reset) begin
        if (reset) en_seen <= 1'b0;
        else       en_seen <= bus.enable;
    end

    // Monitor: every strobed edge owes one scoreboard entry; idle edges must not pulse done
    always @(negedge clock) begin
        exp_t e;
        if (bus.out_done === 1'b1) done_cnt++;
        if (!reset) begin
            if (en_seen) begin
                if (sb.size() == 0) begin
                    check_eq("sb_underflow", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check_eq("crc_q",      32'(bus.crc_q),      32'(e.crc));
                    check_eq("out_valid",  32'(bus.out_valid),  32'(e.valid));
                    check_eq("out_bit",    32'(bus.out_bit),    32'(e.obit));
                    check_eq("out_done",   32'(bus.out_done),   32'(e.done));
                    check_eq("crc_zero",   32'(bus.crc_zero),   32'(e.zero));
                    check_eq("err_sticky", 32'(bus.err_sticky), 32'(e.err));
                end
            end else begin
                check_eq("idle_done", 32'(bus.out_done), 32'd0);
            end
        end
    end

    task automatic clear_inputs();
        bus.enable = 1'b0; bus.load = 1'b0; bus.preload = '0; bus.start_out = 1'b0;
        bus.Input = 1'b0; bus.check = 1'b0; bus.err_clr = 1'b0;
    endtask

    // One bit strobe: drive, advance the model, queue the expectation
    task automatic step(input logic ld, input logic [W-1:0] pl, input logic so,
                        input logic in_b, input logic chk_b, input logic clr);
        exp_t        e;
        logic        shifting;
        logic [W:0]  wide;
        bus.enable = 1'b1; bus.load = ld; bus.preload = pl; bus.start_out = so;
        bus.Input = in_b; bus.check = chk_b; bus.err_clr = clr;
        shifting = (emit_q.size() != 0);
        e.done   = 1'b0;
`ifdef CRC_STICKY_ERR_EN
        if (chk_b && !shifting && m_crc != '0) m_err = 1'b1;
        else if (clr)                          m_err = 1'b0;
`endif
        if (!shifting) begin
            if (ld) begin
                m_crc = pl;
            end else if (so) begin
                for (int i = W - 1; i >= 0; i--) emit_q.push_back(m_crc[i]);
            end else begin
                // Multiply by x, add the data term at x^W, reduce modulo the full generator
                wide = {m_crc, 1'b0} ^ ({1'b0, {W{1'b0}}} | ((W+1)'(in_b) << W));
                if (wide[W]) wide = wide ^ {1'b1, POLY};
                m_crc = wide[W-1:0];
            end
        end else begin
            if (ld) begin
                m_crc = pl;
                emit_q.delete();
            end else begin
                void'(emit_q.pop_front());
                m_crc = m_crc << 1;
                if (emit_q.size() == 0) e.done = 1'b1;
            end
        end
        e.crc   = m_crc;
        e.valid = (emit_q.size() != 0);
        e.obit  = e.valid ? emit_q[0] : 1'b0;
        e.zero  = (m_crc == '0);
        e.err   = m_err;
        sb.push_back(e);
        @(posedge clock); #1;
        clear_inputs();
    endtask

    task automatic idle(input int n, input logic clr);
        for (int k = 0; k < n; k++) begin
            bus.err_clr = clr;
`ifdef CRC_STICKY_ERR_EN
            if (clr) m_err = 1'b0;
`endif
            @(posedge clock); #1;
            bus.err_clr = 1'b0;
        end
    endtask

    task automatic feed_bits(input logic [63:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) step(1'b0, '0, 1'b0, v[i], 1'b0, 1'b0);
    endtask

    initial begin
        logic [63:0] msg;
        logic [63:0] msg2;
        logic [W-1:0] crc_val;
        logic [W-1:0] pat;
        logic [W-1:0] hold;
        int           d0;

        n_cmp = 0; n_err = 0; done_cnt = 0;
        m_crc = '0; m_err = 1'b0;
        clear_inputs();
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        check_eq("rst_crc",   32'(bus.crc_q),      32'd0);
        check_eq("rst_valid", 32'(bus.out_valid),  32'd0);
        check_eq("rst_done",  32'(bus.out_done),   32'd0);
        check_eq("rst_zero",  32'(bus.crc_zero),   32'd1);
        check_eq("rst_err",   32'(bus.err_sticky), 32'd0);
        reset = 1'b0;
        @(posedge clock); #1;

        // T2: first two LFSR steps from zero
        step(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
        check_eq("t2_first",  32'(bus.crc_q), 32'h4599);
        step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("t2_second", 32'(bus.crc_q), 32'h4EAB);

        // T3: message followed by its own CRC leaves zero remainder; a flipped bit does not
        msg = {$urandom, $urandom};
        step(1'b1, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        feed_bits(msg, 64);
        crc_val = m_crc;
        feed_bits({49'd0, crc_val}, W);
        check_eq("t3_good_zero", 32'(bus.crc_zero), 32'd1);
        msg2 = msg ^ (64'd1 << $urandom_range(63, 0));
        step(1'b1, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        feed_bits(msg2, 64);
        feed_bits({49'd0, crc_val}, W);
        check_eq("t3_bad_zero", 32'(bus.crc_zero), 32'd0);

        // T4: serialise 0x5555
        pat = 15'h5555;
        step(1'b1, pat, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
        d0 = done_cnt;
        for (int i = W - 1; i >= 0; i--) begin
            check_eq("t4_out_bit", 32'(bus.out_bit), 32'(pat[i]));
            step(1'b0, '0, 1'b0, $urandom_range(1, 0), 1'b1, 1'b0);
        end
        idle(2, 1'b0);
        check_eq("t4_done_pulses", 32'(done_cnt - d0), 32'd1);
        check_eq("t4_crc_zero",    32'(bus.crc_q),     32'd0);
        check_eq("t4_calc",        32'(bus.out_valid), 32'd0);

        // T5: load beats start_out; load aborts a shift; idle holds
        step(1'b1, 15'h0123, 1'b1, 1'b1, 1'b0, 1'b0);
        check_eq("t5_load_crc",   32'(bus.crc_q),     32'h0123);
        check_eq("t5_load_valid", 32'(bus.out_valid), 32'd0);
        step(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
        repeat (7) step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        d0 = done_cnt;
        step(1'b1, 15'h2ACE, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(1, 1'b0);
        check_eq("t5_abort_valid", 32'(bus.out_valid), 32'd0);
        check_eq("t5_abort_done",  32'(done_cnt - d0), 32'd0);
        hold = m_crc;
        for (int k = 0; k < 10; k++) begin
            bus.Input = 1'b1; bus.start_out = 1'b1; bus.load = 1'b1; bus.preload = 15'h7FFF;
            idle(1, 1'b0);
            clear_inputs();
            check_eq("t5_hold", 32'(bus.crc_q), 32'(hold));
        end

        // T6: sticky error behaviour (expected 0 throughout without the feature)
        step(1'b1, 15'h0001, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 15'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 15'h0042, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b1);
        idle(1, 1'b1);
        check_eq("t6_clr_alone", 32'(bus.err_sticky), 32'd0);

        // Randomised traffic
        for (int n = 0; n < 200; n++) begin
            step(($urandom % 16) == 0, W'($urandom), ($urandom % 12) == 0,
                 $urandom_range(1, 0), $urandom_range(1, 0), ($urandom % 8) == 0);
            if (($urandom % 5) == 0) idle(1, 1'b0);
        end

        // T1: asynchronous reset five bits into a shift
        step(1'b1, 15'h6B3D, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
        repeat (5) step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clock); #1;
        reset = 1'b1;
        #1;
        check_eq("t1_crc",   32'(bus.crc_q),     32'd0);
        check_eq("t1_valid", 32'(bus.out_valid), 32'd0);
        check_eq("t1_done",  32'(bus.out_done),  32'd0);
        m_crc = '0; m_err = 1'b0; emit_q.delete();
        @(posedge clock); #1;
        reset = 1'b0;
        step(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);

        repeat (3) @(negedge clock);
        check_eq("sb_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
